// File: rtl/conv_encoder_pkg.sv
// Shared code definitions for the convolutional encoder/decoder pair:
// default code parameters, puncture patterns and FSM state encodings.
package conv_encoder_pkg;

    localparam int unsigned DEF_K  = 7;
    localparam int unsigned DEF_G0 = 'o171;
    localparam int unsigned DEF_G1 = 'o133;

    localparam logic [3:0] RATE_1_2 = 4'b1111;
    localparam logic [3:0] RATE_2_3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_t;

    // Two-phase puncture pattern: [1:0] is the phase-0 mask, [3:2] the phase-1 mask.
    function automatic logic [1:0] phase_mask(input logic [3:0] pat, input logic phase);
        return phase ? pat[3:2] : pat[1:0];
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / symbol-out stream of the convolutional encoder.
interface conv_encoder_if;

    logic       i_vld;
    logic       i_bit;
    logic       o_rdy;
    logic       o_vld;
    logic       i_rdy;
    logic [1:0] o_sym;
    logic [1:0] o_mask;
    logic       o_eof;

    modport master (
        output i_vld, i_bit, i_rdy,
        input  o_rdy, o_vld, o_sym, o_mask, o_eof
    );

    modport slave (
        input  i_vld, i_bit, i_rdy,
        output o_rdy, o_vld, o_sym, o_mask, o_eof
    );

endinterface

// File: rtl/conv_encoder_parity.sv
// Combinational parity of a K-bit window against both generators; the
// decoder branch path reuses it to re-encode hypotheses.
module conv_parity
    import conv_encoder_pkg::*;
#(
    parameter int unsigned K  = DEF_K,
    parameter int unsigned G0 = DEF_G0,
    parameter int unsigned G1 = DEF_G1
) (
    input  logic [K-1:0] win,
    output logic [1:0]   par
);

    localparam logic [K-1:0] TAP0 = K'(G0);
    localparam logic [K-1:0] TAP1 = K'(G1);

    assign par[0] = ^(win & TAP0);
    assign par[1] = ^(win & TAP1);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with zero-tail termination
// and a two-phase puncture mask attached to every output symbol.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int unsigned K         = DEF_K,
    parameter int unsigned G0        = DEF_G0,
    parameter int unsigned G1        = DEF_G1,
    parameter int unsigned FRAME_LEN = 64,
    parameter logic [3:0]  PUNCT_PAT = RATE_1_2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_start,
    output logic          o_busy,
    conv_encoder_if.slave strm
);

    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int TAIL_W = $clog2(K);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(K - 2);
    localparam logic [TAIL_W-1:0] TAIL_END  = TAIL_W'(K - 1);

    enc_state_t        state_q, state_d;
    logic [K-2:0]      shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TAIL_W-1:0] tail_cnt_q;
    logic              phase_q;

    logic         in_data, in_tail, tail_left, slot_free, load;
    logic         last_bit, last_tail, eof_accept;
    logic [K-1:0] window;
    logic [1:0]   par, mask;

    assign in_data    = (state_q == ST_DATA);
    assign in_tail    = (state_q == ST_TAIL);
    // Once all K-1 tail symbols are loaded, TAIL only waits for the eof handoff.
    assign tail_left  = (tail_cnt_q != TAIL_END);
    assign slot_free  = !strm.o_vld || strm.i_rdy;
    assign load       = slot_free && ((in_data && strm.i_vld) || (in_tail && tail_left));
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign last_tail  = (tail_cnt_q == LAST_TAIL);
    assign eof_accept = strm.o_vld && strm.i_rdy && strm.o_eof;
    assign window     = {in_data ? strm.i_bit : 1'b0, shift_q};
    assign mask       = phase_mask(PUNCT_PAT, phase_q);

    assign strm.o_rdy = in_data && slot_free;
    assign o_busy     = (state_q != ST_IDLE);

    conv_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (
        .win (window),
        .par (par)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start)          state_d = ST_DATA;
            ST_DATA: if (load && last_bit) state_d = ST_TAIL;
            ST_TAIL: if (eof_accept)       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            phase_q     <= 1'b0;
            strm.o_vld  <= 1'b0;
            strm.o_sym  <= 2'b00;
            strm.o_mask <= 2'b00;
            strm.o_eof  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && i_start) begin
                shift_q    <= '0;
                bit_cnt_q  <= '0;
                tail_cnt_q <= '0;
                phase_q    <= 1'b0;
            end else if (load) begin
                shift_q <= window[K-1:1];
                phase_q <= !phase_q;
                if (in_data) bit_cnt_q  <= bit_cnt_q + 1'b1;
                else         tail_cnt_q <= tail_cnt_q + 1'b1;
            end
            // Output register: refilled on load, emptied on accept, held while stalled.
            if (load) begin
                strm.o_vld  <= 1'b1;
                strm.o_sym  <= par & mask;
                strm.o_mask <= mask;
                strm.o_eof  <= in_tail && last_tail;
            end else if (strm.i_rdy) begin
                strm.o_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: impulse and punctured impulse frames,
// zero/random 64-bit frames with stalls, mid-frame reset and ignored starts.
module tb_conv_encoder;
    import conv_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_a, start_b, start_c;
    logic busy_a, busy_b, busy_c;

    conv_encoder_if if_a ();
    conv_encoder_if if_b ();
    conv_encoder_if if_c ();

    conv_encoder #(.K(7), .G0('o171), .G1('o133), .FRAME_LEN(1), .PUNCT_PAT(RATE_1_2)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_start(start_a), .o_busy(busy_a), .strm(if_a.slave));
    conv_encoder #(.K(7), .G0('o171), .G1('o133), .FRAME_LEN(64), .PUNCT_PAT(RATE_1_2)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_start(start_b), .o_busy(busy_b), .strm(if_b.slave));
    conv_encoder #(.K(7), .G0('o171), .G1('o133), .FRAME_LEN(1), .PUNCT_PAT(RATE_2_3)) dut_c (
        .clk(clk), .reset_n(reset_n), .i_start(start_c), .o_busy(busy_c), .strm(if_c.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed impulse responses {o_sym[1],o_sym[0]} and masks.
    logic [1:0] imp_sym  [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [1:0] pun_sym  [7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [1:0] pun_mask [7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};

    localparam logic [6:0] G0V = 7'o171;
    localparam logic [6:0] G1V = 7'o133;

    // Textbook convolution: c_j[t] = XOR_i g_j[K-1-i] * u[t-i].
    function automatic logic [1:0] ref_sym(input logic [63:0] u, input int t);
        logic [1:0] c;
        logic       b;
        c = 2'b00;
        for (int i = 0; i < 7; i++) begin
            b = ((t - i) >= 0 && (t - i) < 64) ? u[t - i] : 1'b0;
            c[0] = c[0] ^ (b & G0V[6 - i]);
            c[1] = c[1] ^ (b & G1V[6 - i]);
        end
        return c;
    endfunction

    logic [4:0] sym_a [$];
    logic [4:0] sym_b [$];
    logic [4:0] sym_c [$];
    logic       stall_b = 1'b0;
    logic [4:0] held_b;

    always @(negedge clk) begin
        if (if_a.o_vld && if_a.i_rdy && reset_n) sym_a.push_back({if_a.o_eof, if_a.o_mask, if_a.o_sym});
        if (if_c.o_vld && if_c.i_rdy && reset_n) sym_c.push_back({if_c.o_eof, if_c.o_mask, if_c.o_sym});
        if (stall_b && reset_n)
            chk("b_stall_hold", {26'd0, if_b.o_vld, if_b.o_eof, if_b.o_mask, if_b.o_sym}, {26'd0, 1'b1, held_b});
        stall_b = if_b.o_vld && !if_b.i_rdy && reset_n;
        held_b  = {if_b.o_eof, if_b.o_mask, if_b.o_sym};
        if (if_b.o_vld && if_b.i_rdy && reset_n) sym_b.push_back({if_b.o_eof, if_b.o_mask, if_b.o_sym});
    end

    task automatic run_ac(input bit sel_c);
        int cyc = 0;
        bit done = 0, sent = 0, tail_seen = 0;
        if (sel_c) begin start_c = 1; if_c.i_rdy = 1; end
        else       begin start_a = 1; if_a.i_rdy = 1; end
        tick();
        start_a = 0; start_c = 0;
        chk("busy_rise", sel_c ? busy_c : busy_a, 1);
        if (sel_c) begin if_c.i_vld = 1; if_c.i_bit = 1; end
        else       begin if_a.i_vld = 1; if_a.i_bit = 1; end
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (sel_c) begin
                if (if_c.o_rdy && if_c.i_vld) sent = 1;
                if (if_c.o_vld && if_c.o_eof) begin
                    done = 1;
                    start_c = 1;
                    chk("c_busy_at_eof", busy_c, 1);
                end
            end else begin
                if (sent && !tail_seen) begin
                    chk("a_rdy_in_tail", if_a.o_rdy, 0);
                    tail_seen = 1;
                end
                if (if_a.o_rdy && if_a.i_vld) sent = 1;
                if (if_a.o_vld && if_a.o_eof) begin
                    done = 1;
                    chk("a_busy_at_eof", busy_a, 1);
                end
            end
            tick();
            cyc++;
            start_c = 0;
            if (sent) begin if_a.i_vld = 0; if_c.i_vld = 0; end
        end
        chk("ac_frame_done", done, 1);
        @(negedge clk);
        chk("ac_busy_fall", sel_c ? busy_c : busy_a, 0);
        repeat (4) tick();
        chk("ac_stay_idle", sel_c ? busy_c : busy_a, 0);
        chk("ac_sym_count", sel_c ? sym_c.size() : sym_a.size(), 7);
    endtask

    task automatic run_b(input logic [63:0] u, input bit rnd, input int stop_at);
        int idx = 0, cyc = 0;
        bit done = 0;
        start_b = 1;
        tick();
        start_b = 0;
        while (!done && cyc < 3000) begin
            if (idx == stop_at) break;
            if_b.i_vld = (idx < 64) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            if_b.i_bit = (idx < 64) ? u[idx] : 1'b0;
            if_b.i_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            start_b    = (!rnd && idx == 10);
            @(negedge clk);
            if (if_b.o_rdy && if_b.i_vld) idx++;
            if (if_b.o_vld && if_b.i_rdy && if_b.o_eof) begin
                done = 1;
                chk("b_busy_at_eof", busy_b, 1);
            end
            tick();
            cyc++;
        end
        if_b.i_vld = 0;
        start_b    = 0;
        if (stop_at < 0) begin
            chk("b_frame_done", done, 1);
            chk("b_bits_used", idx, 64);
            if_b.i_rdy = 1;
            @(negedge clk);
            chk("b_busy_fall", busy_b, 0);
            tick();
        end
    endtask

    task automatic check_b(input string tag, input logic [63:0] u);
        int errs = 0, eofs = 0;
        chk({tag, "_count"}, sym_b.size(), 70);
        for (int t = 0; t < sym_b.size() && t < 70; t++) begin
            if (sym_b[t] !== {t == 69, 2'b11, ref_sym(u, t)}) begin
                errs++;
                $display("FAIL %s_sym[%0d]: got 0x%0h expected 0x%0h", tag, t, sym_b[t], {t == 69, 2'b11, ref_sym(u, t)});
            end
            if (sym_b[t][4]) eofs++;
        end
        chk({tag, "_sym_errs"}, errs, 0);
        chk({tag, "_eof_count"}, eofs, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] payload;
        reset_n = 0;
        start_a = 0; start_b = 0; start_c = 0;
        if_a.i_vld = 0; if_a.i_bit = 0; if_a.i_rdy = 0;
        if_b.i_vld = 0; if_b.i_bit = 0; if_b.i_rdy = 0;
        if_c.i_vld = 0; if_c.i_bit = 0; if_c.i_rdy = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy",  busy_b, 0);
        chk("rst_vld",   if_b.o_vld, 0);
        chk("rst_rdy",   if_b.o_rdy, 0);
        chk("rst_sym",   {if_b.o_sym, if_b.o_mask}, 0);
        chk("rst_eof",   if_b.o_eof, 0);
        tick();
        reset_n = 1;
        tick();

        run_ac(0);
        for (int t = 0; t < sym_a.size() && t < 7; t++)
            chk("impulse_sym", sym_a[t], {t == 6, 2'b11, imp_sym[t]});

        run_ac(1);
        for (int t = 0; t < sym_c.size() && t < 7; t++)
            chk("punct_sym", sym_c[t], {t == 6, pun_mask[t], pun_sym[t]});

        // All-zero frame, with a stray i_start in mid-DATA.
        run_b(64'd0, 0, -1);
        check_b("zero", 64'd0);
        sym_b.delete();

        payload = {$urandom, $urandom};
        run_b(payload, 1, -1);
        check_b("random", payload);
        sym_b.delete();

        // Reset while the 31st bit is pending, then an impulse frame from zero state.
        run_b({64{1'b1}}, 0, 30);
        reset_n = 0;
        tick();
        @(negedge clk);
        chk("midrst_busy", busy_b, 0);
        chk("midrst_outs", {if_b.o_vld, if_b.o_rdy, if_b.o_eof, if_b.o_sym, if_b.o_mask}, 0);
        tick();
        reset_n = 1;
        sym_b.delete();
        tick();
        run_b(64'd1, 0, -1);
        check_b("post_rst", 64'd1);
        for (int t = 0; t < sym_b.size() && t < 7; t++)
            chk("post_rst_imp", sym_b[t][1:0], imp_sym[t]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
